pixel_array_ctrl: RTL and testbench

//  Controller/readout end of the pixel sensor interface. Sequences one frame: erase, expose,

---
 rtl/pixel_array_ctrl_pkg.sv | 18 +
 rtl/pixel_array_ctrl_counter.sv | 22 ++
 rtl/pixel_array_ctrl.sv | 135 +++++++++++++
 tb/tb_pixel_array_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_array_ctrl_pkg.sv
// Shared types and defaults for the pixel array readout controller.
// The FSM state encoding is shared with the controller and any checker bound to it.
package pixel_ctrl_pkg;

    localparam int PIXEL_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        RD_SETTLE,
        RD_CAPTURE,
        STREAM,
        DONE
    } state_t;

endpackage

// File: rtl/pixel_array_ctrl_counter.sv
// Up-counter with asynchronous reset, synchronous clear (wins over enable) and count enable.
module pixel_array_ctrl_counter #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    output logic [BITS-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the pixel array: erase, expose, ramp conversion, then row-by-row
// capture and valid/ready streaming of each pixel sample.
module pixel_array_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int PIXEL_BITS    = PIXEL_BITS_DEFAULT,
    parameter int ROWS          = 2,
    parameter int COLS          = 2,
    parameter int ERASE_CYCLES  = 5,
    parameter int EXPOSE_CYCLES = 255,
    localparam int ROW_BITS     = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int COL_BITS     = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start_i,
    output logic                       erase_o,
    output logic                       expose_o,
    output logic                       ramp_o,
    output logic [PIXEL_BITS-1:0]      counter_o,
    output logic [ROWS-1:0]            read_o,
    input  logic [COLS*PIXEL_BITS-1:0] pix_data_i,
    output logic [PIXEL_BITS-1:0]      out_data_o,
    output logic [ROW_BITS-1:0]        out_row_o,
    output logic [COL_BITS-1:0]        out_col_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       busy_o,
    output logic                       frame_done_o,
    output state_t                     fsm_state
);

    // Handshake: a pixel transfers on a clock edge where out_valid_o and out_ready_i are
    // both high; while valid is high and ready low, data and indices stay unchanged.

    localparam int CONV_CYCLES = 2 << PIXEL_BITS;
    localparam int PHASE_MAX   = (ERASE_CYCLES > EXPOSE_CYCLES)
                               ? ((ERASE_CYCLES > CONV_CYCLES) ? ERASE_CYCLES : CONV_CYCLES)
                               : ((EXPOSE_CYCLES > CONV_CYCLES) ? EXPOSE_CYCLES : CONV_CYCLES);
    localparam int TIMER_BITS  = $clog2(PHASE_MAX + 1);

    state_t                  state;
    state_t                  state_next;
    logic [TIMER_BITS-1:0]   timer;
    logic [ROW_BITS-1:0]     row;
    logic [COL_BITS-1:0]     col;
    logic [PIXEL_BITS-1:0]   row_buf [COLS];
    logic                    xfer;
    logic                    col_last;
    logic                    row_last;
    logic                    conv_last;

    assign xfer      = out_valid_o & out_ready_i;
    assign col_last  = (col == COL_BITS'(COLS - 1));
    assign row_last  = (row == ROW_BITS'(ROWS - 1));
    assign conv_last = (timer == TIMER_BITS'(CONV_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (start_i) state_next = ERASE;
            ERASE:      if (timer == TIMER_BITS'(ERASE_CYCLES - 1)) state_next = EXPOSE;
            EXPOSE:     if (timer == TIMER_BITS'(EXPOSE_CYCLES - 1)) state_next = CONVERT;
            CONVERT:    if (conv_last) state_next = RD_SETTLE;
            RD_SETTLE:  state_next = RD_CAPTURE;
            RD_CAPTURE: state_next = STREAM;
            STREAM:     if (xfer && col_last) state_next = row_last ? DONE : RD_SETTLE;
            DONE:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Phase timer restarts from 0 on every state change; its LSB doubles as the ramp.
    pixel_array_ctrl_counter #(.BITS(TIMER_BITS)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_next != state),
        .enable (state != IDLE),
        .count  (timer)
    );

    // Conversion count steps after each ramp-high cycle and holds its final value until IDLE.
    pixel_array_ctrl_counter #(.BITS(PIXEL_BITS)) u_conv_count (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_next == IDLE),
        .enable ((state == CONVERT) && timer[0] && !conv_last),
        .count  (counter_o)
    );

    pixel_array_ctrl_counter #(.BITS(ROW_BITS)) u_row (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == IDLE),
        .enable (xfer && col_last && !row_last),
        .count  (row)
    );

    pixel_array_ctrl_counter #(.BITS(COL_BITS)) u_col (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state == IDLE) || (xfer && col_last)),
        .enable (xfer),
        .count  (col)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < COLS; c++) row_buf[c] <= '0;
        end else if (state == RD_CAPTURE) begin
            for (int c = 0; c < COLS; c++) row_buf[c] <= pix_data_i[c*PIXEL_BITS +: PIXEL_BITS];
        end
    end

    assign erase_o      = (state == ERASE);
    assign expose_o     = (state == EXPOSE);
    assign ramp_o       = (state == CONVERT) && timer[0];
    assign read_o       = ((state == RD_SETTLE) || (state == RD_CAPTURE)) ? (ROWS'(1) << row) : '0;
    assign out_valid_o  = (state == STREAM);
    assign out_data_o   = out_valid_o ? row_buf[col] : '0;
    assign out_row_o    = out_valid_o ? row : '0;
    assign out_col_o    = out_valid_o ? col : '0;
    assign busy_o       = (state != IDLE);
    assign frame_done_o = (state == DONE);
    assign fsm_state    = state;

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Bench for pixel_array_ctrl driving a 2x2 array of behavioural pixel sensors.
module tb_pixel_array_ctrl;
    import pixel_ctrl_pkg::*;

    localparam int PB      = 8;
    localparam int ROWS    = 2;
    localparam int COLS    = 2;
    localparam int EC      = 5;
    localparam int XC      = 3;
    localparam int NPIX    = ROWS * COLS;
    localparam int LATENCY = 1 + EC + XC + 2 * 256 + ROWS * (2 + COLS) + 1;

    logic              clk;
    logic              reset;
    logic              start_i;
    logic              erase_o;
    logic              expose_o;
    logic              ramp_o;
    logic [PB-1:0]     counter_o;
    logic [ROWS-1:0]   read_o;
    logic [COLS*PB-1:0] pix_data_i;
    logic [PB-1:0]     out_data_o;
    logic              out_row_o;
    logic              out_col_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              busy_o;
    logic              frame_done_o;
    state_t            fsm_state;

    pixel_array_ctrl #(
        .PIXEL_BITS    (PB),
        .ROWS          (ROWS),
        .COLS          (COLS),
        .ERASE_CYCLES  (EC),
        .EXPOSE_CYCLES (XC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .erase_o      (erase_o),
        .expose_o     (expose_o),
        .ramp_o       (ramp_o),
        .counter_o    (counter_o),
        .read_o       (read_o),
        .pix_data_i   (pix_data_i),
        .out_data_o   (out_data_o),
        .out_row_o    (out_row_o),
        .out_col_o    (out_col_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .fsm_state    (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- sensor models ----------------
    logic [PB-1:0] sens_v [NPIX];
    int            lvl    [NPIX];
    logic [PB-1:0] lat    [NPIX];
    logic          latd   [NPIX];

    initial begin
        for (int i = 0; i < NPIX; i++) begin
            sens_v[i] = '0;
            lvl[i]    = 0;
            lat[i]    = '0;
            latd[i]   = 1'b0;
        end
    end

    // Each sensor integrates its value per EXPOSE cycle, then latches COUNTER when the ramp crosses.
    always @(negedge clk) begin
        for (int i = 0; i < NPIX; i++) begin
            if (erase_o) begin
                lvl[i]  = 0;
                lat[i]  = '0;
                latd[i] = 1'b0;
            end else if (expose_o) begin
                lvl[i] = lvl[i] + int'(sens_v[i]);
            end else if (ramp_o && !latd[i] && int'(counter_o) >= lvl[i]) begin
                lat[i]  = counter_o;
                latd[i] = 1'b1;
            end
        end
    end

    always_comb begin
        pix_data_i = 16'hA55A;
        for (int r = 0; r < ROWS; r++) begin
            if (read_o[r]) begin
                for (int c = 0; c < COLS; c++) pix_data_i[c*PB +: PB] = lat[r*COLS + c];
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [9:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [3:0][7:0] v;
        logic [3:0][7:0] exp_pix;
        int              stall_pix;
        int              stall_len;
    } frame_vec_t;

    frame_vec_t vecs [3];

    // ---------------- driver tasks ----------------
    task automatic run_frame(input int idx);
        frame_vec_t fv;
        logic [9:0] e;
        int  cyc, accepted, stall_left, erase_n, expose_n, overlap, rises, viol, extra, busy_n;
        logic       prev_ramp;
        logic [7:0] prev_cnt;
        bit  seen_done;
        fv = vecs[idx];
        for (int p = 0; p < NPIX; p++) begin
            sens_v[p] = fv.v[p];
            exp_q.push_back({1'(p / COLS), 1'(p % COLS), fv.exp_pix[p]});
        end
        accepted = 0; erase_n = 0; expose_n = 0; overlap = 0; rises = 0; viol = 0;
        prev_ramp = 1'b0; prev_cnt = '0; seen_done = 0;
        stall_left = fv.stall_len;
        @(negedge clk);
        start_i = 1'b1;
        cyc = 1;
        while (!seen_done && cyc < LATENCY + 100) begin
            @(negedge clk);
            cyc++;
            start_i = (cyc == 50 || cyc == 400);
            if (out_valid_o && accepted == fv.stall_pix && stall_left > 0) begin
                out_ready_i = 1'b0;
                stall_left--;
            end else if (out_valid_o) begin
                out_ready_i = 1'b1;
            end else begin
                out_ready_i = 1'($urandom_range(0, 1));
            end
            #1;
            if (erase_o) erase_n++;
            if (expose_o) expose_n++;
            if (erase_o && expose_o) overlap++;
            if (ramp_o && !prev_ramp) rises++;
            if (counter_o != prev_cnt && !(counter_o == prev_cnt + 8'd1 && !ramp_o && prev_ramp)) viol++;
            if ($countones(read_o) > 1 || (read_o != '0 && out_valid_o)) viol++;
            prev_cnt  = counter_o;
            prev_ramp = ramp_o;
            if (out_valid_o && exp_q.size() > 0) begin
                e = exp_q[0];
                if (!out_ready_i) begin
                    check("stall_data", 32'(out_data_o), 32'(e[7:0]));
                    check("stall_col", 32'(out_col_o), 32'(e[8]));
                end else begin
                    e = exp_q.pop_front();
                    check("pix_data", 32'(out_data_o), 32'(e[7:0]));
                    check("pix_row", 32'(out_row_o), 32'(e[9]));
                    check("pix_col", 32'(out_col_o), 32'(e[8]));
                    accepted++;
                end
            end else if (out_valid_o && out_ready_i) begin
                checks++;
                errors++;
                $display("FAIL extra_pixel: got data %0h with empty queue", out_data_o);
            end
            if (frame_done_o) begin
                seen_done = 1;
                check("done_latency", 32'(cyc), 32'(LATENCY + fv.stall_len));
                check("done_after_pixels", 32'(accepted), 32'(NPIX));
                check("counter_held", 32'(counter_o), 32'd255);
                check("done_valid_low", 32'(out_valid_o), 32'd0);
            end
        end
        start_i = 1'b0;
        if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no frame_done in %0d cycles", cyc);
        end
        check("erase_cycles", 32'(erase_n), 32'(EC));
        check("expose_cycles", 32'(expose_n), 32'(XC));
        check("erase_expose_overlap", 32'(overlap), 32'd0);
        check("ramp_rises", 32'(rises), 32'd256);
        check("counter_read_violations", 32'(viol), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        extra = 0; busy_n = 0; viol = 0;
        repeat (20) begin
            @(negedge clk);
            out_ready_i = 1'b1;
            #1;
            if (frame_done_o) extra++;
            if (busy_o) busy_n++;
            if (counter_o != '0) viol++;
        end
        check("extra_frame_done", 32'(extra), 32'd0);
        check("idle_busy", 32'(busy_n), 32'd0);
        check("idle_counter_zero", 32'(viol), 32'd0);
        exp_q.delete();
    endtask

    task automatic reset_mid_convert();
        bit found;
        int done_n, busy_n;
        found = 0;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 800 && !found; k++) begin
            @(negedge clk);
            if (counter_o == 8'h40) found = 1;
        end
        check("reach_counter_40", 32'(found), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_outputs", 32'({erase_o, expose_o, ramp_o, counter_o, read_o, out_data_o,
                                  out_row_o, out_col_o, out_valid_o, frame_done_o}), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        done_n = 0; busy_n = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (frame_done_o) done_n++;
            if (busy_o) busy_n++;
        end
        check("rst_no_frame_done", 32'(done_n), 32'd0);
        check("rst_stays_idle", 32'(busy_n), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset       = 1'b1;
        start_i     = 1'b0;
        out_ready_i = 1'b0;
        vecs[0] = '{v: {8'd4, 8'd2, 8'd2, 8'd1},      exp_pix: {8'd12, 8'd6, 8'd6, 8'd3},
                    stall_pix: -1, stall_len: 0};
        vecs[1] = '{v: {8'd40, 8'd30, 8'd20, 8'd10},  exp_pix: {8'd120, 8'd90, 8'd60, 8'd30},
                    stall_pix: 1, stall_len: 3};
        vecs[2] = '{v: {8'd85, 8'd50, 8'd0, 8'd80},   exp_pix: {8'd255, 8'd150, 8'd0, 8'd240},
                    stall_pix: 3, stall_len: 2};
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", 32'({erase_o, expose_o, ramp_o, counter_o, read_o, out_data_o,
                                    out_row_o, out_col_o, out_valid_o, frame_done_o}), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) run_frame(i);
        reset_mid_convert();
        run_frame(0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
